vga_frame_scheduler: RTL and testbench
======================================

// Module: vga_frame_scheduler
// PURPOSE
//  Sequences per-frame work against the free-running VGA position counter (1-based HPos/VPos).
//  - Registers the sync and active-video strobes.
//  - Opens a per-frame update window for game logic (ball move) in vertical blanking, using a req/ack/done handshake.
//  - Enforces a deadline before the next visible frame and counts missed updates.
//  Sits between the position counter and the ball/pixel logic.
// PARAMETERS
//  H_VISIBLE   640  visible pixels per line
//  H_FRONT     16   horizontal front porch, clocks
//  H_SYNC      96   horizontal sync width, clocks
//  V_VISIBLE   480  visible lines per frame
//  V_FRONT     10   vertical front porch, lines
//  V_SYNC      2    vertical sync width, lines
//  DEADLINE_LN 2    lines before V_MAX at which an unfinished update is aborted
// PORTS
//  i_Clk        in   1   pixel clock
//  i_Reset      in   1   asynchronous reset, active-high
//  i_HPos       in   10  horizontal position, 1..`H_MAX
//  i_VPos       in   10  vertical position, 1..`V_MAX
//  i_Enable     in   1   allow new update requests
//  i_UpdAck     in   1   game logic accepted request
//  i_UpdDone    in   1   game logic finished update
//  o_HSync      out  1   horizontal sync, active-low, registered
//  o_VSync      out  1   vertical sync, active-low, registered
//  o_Active     out  1   visible-area strobe, registered
//  o_UpdReq     out  1   update request, level
//  o_Commit     out  1   one-cycle pulse: latch new game state
//  o_Abort      out  1   one-cycle pulse: update missed deadline
//  o_DropCnt    out  8   aborted updates, saturates at 255
//  o_FrameCnt   out  16  completed frames, wraps
// BEHAVIOUR
//  - Reset values: o_HSync=1, o_VSync=1, all other outputs 0; FSM=IDLE. Reset mid-handshake drops the request with no Commit or Abort.
//  - Strobe latency: 1 clock from i_HPos/i_VPos.
//  - o_Active=1 iff HPos<=H_VISIBLE && VPos<=V_VISIBLE.
//  - o_HSync=0 iff HPos in [H_VISIBLE+H_FRONT+1, H_VISIBLE+H_FRONT+H_SYNC]. o_VSync follows the same rule on VPos.
//  - FrameEnd event: HPos==`H_MAX && VPos==`V_MAX. On it, o_FrameCnt+1, wrapping 65535->0.
//  - VBlankStart event: HPos==`H_MAX && VPos==V_VISIBLE.
//  - Deadline event: HPos==`H_MAX && VPos==`V_MAX-DEADLINE_LN.
//  - FSM states:
//    IDLE: on VBlankStart && i_Enable -> REQ, o_UpdReq=1 next clock.
//    REQ: o_UpdReq held until i_UpdAck is sampled high. Then o_UpdReq=0 next clock -> BUSY.
//    BUSY: i_UpdDone -> COMMIT.
//    COMMIT: o_Commit=1 for one clock -> IDLE.
//    REQ or BUSY at Deadline: o_Abort pulse, o_DropCnt+1 (saturating), o_UpdReq=0 -> IDLE.
//  - Handshake rules:
//    i_UpdAck and i_UpdDone are ignored outside REQ and BUSY respectively.
//    i_UpdAck and i_UpdDone both high in REQ: the ack is taken, then COMMIT on the next clock.
//    i_UpdDone coincident with Deadline in BUSY: Done wins, Commit and no Abort.
//    i_Enable low only blocks entry from IDLE; an update in flight completes.
//  - At most one request per frame. VBlankStart while not in IDLE is ignored.
//  - Position compares are 10-bit unsigned. Derived bounds are localparams; no runtime arithmetic on parameters.
// STRUCTURE
//  - Shared include VgaTiming.v (`H_MAX, `V_MAX) also receives the H_/V_ porch and sync constants and the FSM state encoding (2-bit localparams).
//  - One natural sub-module: vga_sync_decode (strobe generation from HPos/VPos). The FSM stays in this top.
// TESTING
//  1. Reset asserted asynchronously mid-BUSY -> outputs at reset values immediately; no Commit or Abort after release.
//  2. Sweep a full frame -> o_HSync low exactly HPos 657..752; o_VSync low exactly VPos 491..492; o_Active count 307200.
//  3. Ack 3 clocks after req, Done 100 clocks later -> single o_Commit; o_FrameCnt+1 at FrameEnd; o_DropCnt unchanged.
//  4. Never assert Done -> o_Abort at (H_MAX, V_MAX-2) +1 clk; o_DropCnt=1; after 300 such frames o_DropCnt=255.
//  5. Done on the Deadline cycle -> o_Commit, no o_Abort. Ack+Done same clock in REQ -> Commit one clock later.
//  6. i_Enable low at VBlankStart -> no o_UpdReq that frame. i_Enable dropped during BUSY -> Commit still issued.

Source files
------------

// File: rtl/vga_frame_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// vga_frame_scheduler_pkg
// Shared timing constants, the update-FSM state type and small helpers for the
// VGA frame scheduler and its sync decoder.
//   - Default 640x480@60 porch/sync widths (visible, front, sync, back).
//   - upd_state_e: 2-bit encoding of the per-frame update handshake FSM.
//   - sat_inc8: saturating 8-bit increment used by the drop counter.
// ---------------------------------------------------------------------------
package vga_frame_scheduler_pkg;

  // Position counters are 10-bit, 1-based.
  localparam int unsigned POS_W = 10;

  // Default horizontal timing, in pixel clocks.
  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;

  // Default vertical timing, in lines.
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  // Lines before the last line at which an unfinished update is dropped.
  localparam int unsigned DEADLINE_LN_DEF = 2;

  // Update handshake FSM.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StReq    = 2'd1,
    StBusy   = 2'd2,
    StCommit = 2'd3
  } upd_state_e;

  // Increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] i_Val);
    sat_inc8 = (i_Val == 8'hFF) ? i_Val : i_Val + 8'd1;
  endfunction

endpackage

// File: rtl/vga_sync_decode.sv
// ---------------------------------------------------------------------------
// vga_sync_decode
// Decodes the free-running 1-based VGA position into registered sync/active
// strobes and combinational single-cycle frame events.
// Ports:
//   i_Clk, i_Reset        pixel clock, asynchronous active-high reset
//   i_HPos, i_VPos        current position, 1..H_MAX / 1..V_MAX
//   o_HSync, o_VSync      active-low sync, registered (1 clock latency)
//   o_Active              visible-area strobe, registered (1 clock latency)
//   o_FrameEnd            combinational: last pixel of the frame
//   o_VBlankStart         combinational: last pixel of the last visible line
//   o_Deadline            combinational: last pixel of line V_MAX-DEADLINE_LN
// ---------------------------------------------------------------------------
module vga_sync_decode
  import vga_frame_scheduler_pkg::*;
#(
  parameter int unsigned H_VISIBLE   = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT     = H_FRONT_DEF,
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned H_BACK      = H_BACK_DEF,
  parameter int unsigned V_VISIBLE   = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT     = V_FRONT_DEF,
  parameter int unsigned V_SYNC      = V_SYNC_DEF,
  parameter int unsigned V_BACK      = V_BACK_DEF,
  parameter int unsigned DEADLINE_LN = DEADLINE_LN_DEF
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic [POS_W-1:0] i_HPos,
  input  logic [POS_W-1:0] i_VPos,
  output logic             o_HSync,
  output logic             o_VSync,
  output logic             o_Active,
  output logic             o_FrameEnd,
  output logic             o_VBlankStart,
  output logic             o_Deadline
);

  // All bounds are elaboration-time constants; only compares happen at runtime.
  localparam logic [POS_W-1:0] HVisLast   = POS_W'(H_VISIBLE);
  localparam logic [POS_W-1:0] HSyncFirst = POS_W'(H_VISIBLE + H_FRONT + 1);
  localparam logic [POS_W-1:0] HSyncLast  = POS_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [POS_W-1:0] HMax       = POS_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);

  localparam logic [POS_W-1:0] VVisLast   = POS_W'(V_VISIBLE);
  localparam logic [POS_W-1:0] VSyncFirst = POS_W'(V_VISIBLE + V_FRONT + 1);
  localparam logic [POS_W-1:0] VSyncLast  = POS_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [POS_W-1:0] VMax       = POS_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
  localparam logic [POS_W-1:0] VDeadline  =
    POS_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - DEADLINE_LN);

  logic w_LineEnd;
  logic w_HSyncLow;
  logic w_VSyncLow;
  logic w_ActiveNext;

  logic r_HSync;
  logic r_VSync;
  logic r_Active;

  always_comb begin
    w_LineEnd    = (i_HPos == HMax);
    w_HSyncLow   = (i_HPos >= HSyncFirst) && (i_HPos <= HSyncLast);
    w_VSyncLow   = (i_VPos >= VSyncFirst) && (i_VPos <= VSyncLast);
    w_ActiveNext = (i_HPos <= HVisLast) && (i_VPos <= VVisLast);
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_HSync  <= 1'b1;
      r_VSync  <= 1'b1;
      r_Active <= 1'b0;
    end else begin
      r_HSync  <= ~w_HSyncLow;
      r_VSync  <= ~w_VSyncLow;
      r_Active <= w_ActiveNext;
    end
  end

  assign o_HSync  = r_HSync;
  assign o_VSync  = r_VSync;
  assign o_Active = r_Active;

  // Events are left combinational so the scheduler FSM reacts on the same
  // clock edge that samples the position.
  assign o_FrameEnd    = w_LineEnd && (i_VPos == VMax);
  assign o_VBlankStart = w_LineEnd && (i_VPos == VVisLast);
  assign o_Deadline    = w_LineEnd && (i_VPos == VDeadline);

endmodule

// File: rtl/vga_frame_scheduler.sv
// ---------------------------------------------------------------------------
// vga_frame_scheduler
// Sequences one game-logic update per frame against the VGA position counter.
// A request is raised at the start of vertical blanking, acknowledged and
// completed by the game logic, then committed with a one-cycle pulse. An
// update still outstanding DEADLINE_LN lines before the end of the frame is
// aborted and counted.
// Ports:
//   i_Clk, i_Reset        pixel clock, asynchronous active-high reset
//   i_HPos, i_VPos        1-based position from the free-running counter
//   i_Enable              allows a new request at vertical blanking start
//   i_UpdAck, i_UpdDone   game logic handshake (accepted / finished)
//   o_HSync, o_VSync      active-low sync, registered
//   o_Active              visible-area strobe, registered
//   o_UpdReq              update request level
//   o_Commit              one-cycle pulse: latch new game state
//   o_Abort               one-cycle pulse: update missed the deadline
//   o_DropCnt             aborted updates, saturating at 255
//   o_FrameCnt            completed frames, wrapping
// ---------------------------------------------------------------------------
module vga_frame_scheduler
  import vga_frame_scheduler_pkg::*;
#(
  parameter int unsigned H_VISIBLE   = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT     = H_FRONT_DEF,
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned H_BACK      = H_BACK_DEF,
  parameter int unsigned V_VISIBLE   = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT     = V_FRONT_DEF,
  parameter int unsigned V_SYNC      = V_SYNC_DEF,
  parameter int unsigned V_BACK      = V_BACK_DEF,
  parameter int unsigned DEADLINE_LN = DEADLINE_LN_DEF
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic [POS_W-1:0] i_HPos,
  input  logic [POS_W-1:0] i_VPos,
  input  logic             i_Enable,
  input  logic             i_UpdAck,
  input  logic             i_UpdDone,
  output logic             o_HSync,
  output logic             o_VSync,
  output logic             o_Active,
  output logic             o_UpdReq,
  output logic             o_Commit,
  output logic             o_Abort,
  output logic [7:0]       o_DropCnt,
  output logic [15:0]      o_FrameCnt
);

  logic w_FrameEnd;
  logic w_VBlankStart;
  logic w_Deadline;

  upd_state_e r_State;
  upd_state_e w_StateNext;
  logic       w_AbortNext;

  logic        r_Abort;
  logic [7:0]  r_DropCnt;
  logic [15:0] r_FrameCnt;

  vga_sync_decode #(
    .H_VISIBLE   (H_VISIBLE),
    .H_FRONT     (H_FRONT),
    .H_SYNC      (H_SYNC),
    .H_BACK      (H_BACK),
    .V_VISIBLE   (V_VISIBLE),
    .V_FRONT     (V_FRONT),
    .V_SYNC      (V_SYNC),
    .V_BACK      (V_BACK),
    .DEADLINE_LN (DEADLINE_LN)
  ) u_sync_decode (
    .i_Clk         (i_Clk),
    .i_Reset       (i_Reset),
    .i_HPos        (i_HPos),
    .i_VPos        (i_VPos),
    .o_HSync       (o_HSync),
    .o_VSync       (o_VSync),
    .o_Active      (o_Active),
    .o_FrameEnd    (w_FrameEnd),
    .o_VBlankStart (w_VBlankStart),
    .o_Deadline    (w_Deadline)
  );

  // Next-state logic. Ack is only looked at in StReq and Done only in StBusy
  // (or alongside Ack in StReq), so stray handshakes elsewhere are ignored.
  always_comb begin
    w_StateNext = r_State;
    w_AbortNext = 1'b0;
    case (r_State)
      StIdle: begin
        // VBlankStart is the only entry point, which limits us to one
        // request per frame.
        if (w_VBlankStart && i_Enable) begin
          w_StateNext = StReq;
        end
      end
      StReq: begin
        if (w_Deadline) begin
          w_StateNext = StIdle;
          w_AbortNext = 1'b1;
        end else if (i_UpdAck) begin
          // Ack and Done together skip straight to the commit.
          w_StateNext = i_UpdDone ? StCommit : StBusy;
        end
      end
      StBusy: begin
        // Done on the deadline cycle still counts as on time.
        if (i_UpdDone) begin
          w_StateNext = StCommit;
        end else if (w_Deadline) begin
          w_StateNext = StIdle;
          w_AbortNext = 1'b1;
        end
      end
      StCommit: begin
        w_StateNext = StIdle;
      end
      default: begin
        w_StateNext = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_State <= StIdle;
      r_Abort <= 1'b0;
    end else begin
      r_State <= w_StateNext;
      r_Abort <= w_AbortNext;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_DropCnt <= 8'd0;
    end else if (w_AbortNext) begin
      r_DropCnt <= sat_inc8(r_DropCnt);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_FrameCnt <= 16'd0;
    end else if (w_FrameEnd) begin
      r_FrameCnt <= r_FrameCnt + 16'd1;
    end
  end

  // Request and commit are decoded from the state register, so they drop to
  // zero immediately on an asynchronous reset.
  assign o_UpdReq   = (r_State == StReq);
  assign o_Commit   = (r_State == StCommit);
  assign o_Abort    = r_Abort;
  assign o_DropCnt  = r_DropCnt;
  assign o_FrameCnt = r_FrameCnt;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Self-checking bench for vga_frame_scheduler. Frames are compressed: the
// bench jumps the position inputs straight to the interesting events
// (VBlankStart, Deadline, FrameEnd) with random non-event filler between.
module tb_vga_frame_scheduler;

  logic       clk;
  logic       rst;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       en;
  logic       ack;
  logic       done;
  logic       hsync;
  logic       vsync;
  logic       active;
  logic       req;
  logic       commit;
  logic       abort_p;
  logic [7:0] drop;
  logic [15:0] frame;

  int checks;
  int failures;
  int exp_drop;
  int exp_frame;

  vga_frame_scheduler dut (
    .i_Clk      (clk),
    .i_Reset    (rst),
    .i_HPos     (hpos),
    .i_VPos     (vpos),
    .i_Enable   (en),
    .i_UpdAck   (ack),
    .i_UpdDone  (done),
    .o_HSync    (hsync),
    .o_VSync    (vsync),
    .o_Active   (active),
    .o_UpdReq   (req),
    .o_Commit   (commit),
    .o_Abort    (abort_p),
    .o_DropCnt  (drop),
    .o_FrameCnt (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: pulse reset and clear the model counters.
  task automatic do_reset();
    rst = 1'b1;
    hpos = 10'd1; vpos = 10'd1; en = 1'b0; ack = 1'b0; done = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    exp_drop = 0;
    exp_frame = 0;
  endtask

  // One compressed frame. Cycle 0 is VBlankStart, cycle D=f+1 is the deadline,
  // cycle E is FrameEnd. Ack pulses in cycle ta, Done in cycle ta+d.
  // Expected outputs come straight from the timing rules:
  //   request visible in cycles 1..min(ta,D); ack only counts before D;
  //   done counts if it lands at or before D; otherwise abort in cycle D+1.
  task automatic run_frame(input bit e, input bit en_rest, input int f, input int ta,
                           input int d);
    int dl, ef, td, req_last;
    bit ack_ok, commit_ok, exp_req, exp_commit, exp_abort;
    dl = f + 1;
    ef = dl + 2 * f + 8;
    td = ta + d;
    ack_ok = (ta < dl);
    commit_ok = ack_ok && (td <= dl);
    req_last = ack_ok ? ta : dl;
    for (int k = 0; k <= ef + 1; k++) begin
      @(posedge clk);
      #1;
      if (k >= 1) begin
        exp_req    = e && (k <= req_last);
        exp_commit = e && commit_ok && (k == td + 1);
        exp_abort  = e && !commit_ok && (k == dl + 1);
        checks += 3;
        if (req !== exp_req) begin
          failures++;
          $display("FAIL frame_req k=%0d got=%0b exp=%0b", k, req, exp_req);
        end
        if (commit !== exp_commit) begin
          failures++;
          $display("FAIL frame_commit k=%0d got=%0b exp=%0b", k, commit, exp_commit);
        end
        if (abort_p !== exp_abort) begin
          failures++;
          $display("FAIL frame_abort k=%0d got=%0b exp=%0b", k, abort_p, exp_abort);
        end
      end
      if (k == ef + 1) begin
        exp_frame = (exp_frame + 1) % 65536;
        if (e && !commit_ok && exp_drop < 255) exp_drop++;
        checks += 2;
        if (frame !== 16'(exp_frame)) begin
          failures++;
          $display("FAIL frame_cnt got=%0d exp=%0d", frame, exp_frame);
        end
        if (drop !== 8'(exp_drop)) begin
          failures++;
          $display("FAIL drop_cnt got=%0d exp=%0d", drop, exp_drop);
        end
      end
      if (k == 0) begin
        hpos = 10'd800; vpos = 10'd480;
      end else if (k < dl) begin
        hpos = 10'($urandom_range(1, 799)); vpos = 10'($urandom_range(481, 522));
      end else if (k == dl) begin
        hpos = 10'd800; vpos = 10'd523;
      end else if (k < ef) begin
        hpos = 10'($urandom_range(1, 799)); vpos = 10'($urandom_range(523, 525));
      end else if (k == ef) begin
        hpos = 10'd800; vpos = 10'd525;
      end else begin
        hpos = 10'd1; vpos = 10'd1;
      end
      en   = (k == 0) ? e : en_rest;
      ack  = (k == ta);
      done = (k == td);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hpos = 10'd700; vpos = 10'd491; en = 1'b1; ack = 1'b0; done = 1'b0;
    #3;
    checks += 2;
    if ({hsync, vsync, active, req, commit, abort_p} !== 6'b110000) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=110000",
               {hsync, vsync, active, req, commit, abort_p});
    end
    if (drop !== 8'd0 || frame !== 16'd0) begin
      failures++;
      $display("FAIL reset_counts got=%0d/%0d exp=0/0", drop, frame);
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    exp_drop = 0;
    exp_frame = 0;
  endtask

  task automatic test_reset_mid_busy();
    hpos = 10'd800; vpos = 10'd480; en = 1'b1; ack = 1'b0; done = 1'b0;
    @(posedge clk); #1;
    hpos = 10'd1; vpos = 10'd481; ack = 1'b1;
    checks++;
    if (req !== 1'b1) begin
      failures++;
      $display("FAIL rst_busy_req got=%0b exp=1", req);
    end
    @(posedge clk); #1;
    ack = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({hsync, vsync, active, req, commit, abort_p, drop, frame} !==
        {6'b110000, 8'd0, 16'd0}) begin
      failures++;
      $display("FAIL rst_busy_async got=%b/%0d/%0d exp=110000/0/0",
               {hsync, vsync, active, req, commit, abort_p}, drop, frame);
    end
    #2 rst = 1'b0;
    exp_drop = 0;
    exp_frame = 0;
    for (int k = 0; k < 30; k++) begin
      hpos = (k == 10) ? 10'd800 : 10'd5;
      vpos = (k == 10) ? 10'd523 : 10'd500;
      done = (k == 2) || (k == 10);
      @(posedge clk); #1;
      checks++;
      if (req !== 1'b0 || commit !== 1'b0 || abort_p !== 1'b0 || drop !== 8'd0) begin
        failures++;
        $display("FAIL rst_busy_after k=%0d got=%b/%0d exp=000/0",
                 k, {req, commit, abort_p}, drop);
      end
    end
    done = 1'b0;
  endtask

  task automatic test_sync_sweep();
    int hs_low, act_cnt, vs_low;
    bit exp_hs, exp_vs, exp_act;
    en = 1'b0; ack = 1'b0; done = 1'b0;
    hs_low = 0; act_cnt = 0; vs_low = 0;
    for (int h = 1; h <= 800; h++) begin
      hpos = 10'(h); vpos = 10'd5;
      @(posedge clk); #1;
      exp_hs = !(h >= 657 && h <= 752);
      exp_act = (h <= 640);
      if (!hsync) hs_low++;
      if (active) act_cnt++;
      checks++;
      if (hsync !== exp_hs || active !== exp_act || vsync !== 1'b1) begin
        failures++;
        $display("FAIL hsweep h=%0d got=%b exp=%b", h, {hsync, vsync, active},
                 {exp_hs, 1'b1, exp_act});
      end
    end
    checks++;
    if (hs_low != 96 || act_cnt != 640) begin
      failures++;
      $display("FAIL hsweep_count got=%0d/%0d exp=96/640", hs_low, act_cnt);
    end
    act_cnt = 0;
    for (int v = 1; v <= 525; v++) begin
      hpos = 10'd3; vpos = 10'(v);
      @(posedge clk); #1;
      exp_vs = !(v >= 491 && v <= 492);
      exp_act = (v <= 480);
      if (!vsync) vs_low++;
      if (active) act_cnt++;
      checks++;
      if (vsync !== exp_vs || active !== exp_act) begin
        failures++;
        $display("FAIL vsweep v=%0d got=%b exp=%b", v, {vsync, active}, {exp_vs, exp_act});
      end
    end
    checks++;
    if (vs_low != 2 || act_cnt != 480) begin
      failures++;
      $display("FAIL vsweep_count got=%0d/%0d exp=2/480", vs_low, act_cnt);
    end
    for (int i = 0; i < 200; i++) begin
      int h, v;
      h = $urandom_range(1, 799);
      v = $urandom_range(1, 525);
      hpos = 10'(h); vpos = 10'(v);
      @(posedge clk); #1;
      exp_hs = !(h >= 657 && h <= 752);
      exp_vs = !(v >= 491 && v <= 492);
      exp_act = (h <= 640) && (v <= 480);
      checks++;
      if ({hsync, vsync, active} !== {exp_hs, exp_vs, exp_act}) begin
        failures++;
        $display("FAIL sync_rand h=%0d v=%0d got=%b exp=%b", h, v,
                 {hsync, vsync, active}, {exp_hs, exp_vs, exp_act});
      end
    end
    hpos = 10'd1; vpos = 10'd1;
  endtask

  task automatic test_commit();
    int drop_before;
    drop_before = exp_drop;
    run_frame(1'b1, 1'b1, 120, 4, 100);
    checks++;
    if (drop !== 8'(drop_before)) begin
      failures++;
      $display("FAIL commit_drop_unchanged got=%0d exp=%0d", drop, drop_before);
    end
  endtask

  task automatic test_done_edges();
    run_frame(1'b1, 1'b1, 20, 2, 19);  // done lands exactly on the deadline
    run_frame(1'b1, 1'b1, 20, 5, 0);   // ack and done together
    run_frame(1'b1, 1'b1, 20, 30, 1);  // ack never arrives in time
  endtask

  task automatic test_enable();
    int drop_before;
    drop_before = exp_drop;
    run_frame(1'b0, 1'b0, 15, 2, 3);   // no request, stray ack/done ignored
    run_frame(1'b1, 1'b0, 15, 2, 8);   // enable dropped while busy
    checks++;
    if (drop !== 8'(drop_before)) begin
      failures++;
      $display("FAIL enable_drop got=%0d exp=%0d", drop, drop_before);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int f, ta, d;
      bit e;
      f = $urandom_range(5, 40);
      ta = $urandom_range(1, f + 4);
      d = $urandom_range(0, f + 2);
      if (d == 0 && ta == f + 1) d = 1;
      e = ($urandom_range(0, 3) != 0);
      run_frame(e, 1'($urandom_range(0, 1)), f, ta, d);
    end
  endtask

  task automatic test_abort_saturate();
    do_reset();
    run_frame(1'b1, 1'b1, 5, 1, 100000);
    checks++;
    if (drop !== 8'd1) begin
      failures++;
      $display("FAIL abort_first got=%0d exp=1", drop);
    end
    for (int i = 1; i < 300; i++) run_frame(1'b1, 1'b1, 5, 1, 100000);
    checks++;
    if (drop !== 8'd255) begin
      failures++;
      $display("FAIL abort_saturate got=%0d exp=255", drop);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_drop = 0;
    exp_frame = 0;
    test_reset();
    test_reset_mid_busy();
    test_sync_sweep();
    test_commit();
    test_done_edges();
    test_enable();
    test_random();
    test_abort_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
